// File: rtl/student_ser16.sv
// rtl/student_ser16.sv - framed 16-bit parallel-to-serial transmitter (start 0, LSB first, stop 1)
module student_ser16 #(
    parameter int CYCLES_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy
);

    localparam logic [15:0] LAST_TICK = 16'(CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic [3:0]  index, index_n;
    logic [15:0] shift, shift_n;
    logic        tx_n;
    logic        busy_n;
    logic        bit_end;
    logic        xfer;

    assign bit_end  = (timer == LAST_TICK);
    // Ready in IDLE and in the final STOP cycle so frames can abut with no gap.
    assign in_ready = (state == IDLE) || ((state == STOP) && bit_end);
    assign xfer     = in_valid && in_ready;

    // State, timer, shift register and the registered line/busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            index <= '0;
            shift <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            index <= index_n;
            shift <= shift_n;
            tx    <= tx_n;
            busy  <= busy_n;
        end
    end

    // Next-state logic; tx_n/busy_n describe the line as it must look after the edge.
    always_comb begin
        state_n = state;
        timer_n = (state == IDLE || bit_end) ? 16'd0 : timer + 16'd1;
        index_n = index;
        shift_n = shift;
        tx_n    = tx;
        busy_n  = busy;
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (xfer) begin
                    state_n = START;
                    shift_n = in;
                    index_n = 4'd0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    index_n = 4'd0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (index == 4'd15) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n = shift >> 1;
                        index_n = index + 4'd1;
                        tx_n    = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (xfer) begin
                        state_n = START;
                        shift_n = in;
                        index_n = 4'd0;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = 16'd0;
                index_n = 4'd0;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_student_ser16.sv
// tb/tb_student_ser16.sv - scoreboard bench for student_ser16 at N=4 and N=1
module tb_student_ser16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in4, in1;
    logic        v4, v1;
    logic        rdy4, rdy1, tx4, tx1, busy4, busy1;
    bit          mon_en;
    int          errors = 0;
    int          checks = 0;
    bit          q4[$];
    bit          q1[$];

    always #5 clk = ~clk;

    student_ser16 #(.CYCLES_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .in(in4), .in_valid(v4),
        .in_ready(rdy4), .tx(tx4), .busy(busy4)
    );

    student_ser16 #(.CYCLES_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .in(in1), .in_valid(v1),
        .in_ready(rdy1), .tx(tx1), .busy(busy1)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Expected line image of one frame, one entry per clock while busy.
    function automatic void push_frame(int sel, logic [15:0] w);
        int n;
        bit b;
        n = (sel == 0) ? 4 : 1;
        for (int k = 0; k < 18; k++) begin
            b = (k == 0) ? 1'b0 : (k == 17) ? 1'b1 : w[k-1];
            for (int r = 0; r < n; r++) begin
                if (sel == 0) q4.push_back(b);
                else          q1.push_back(b);
            end
        end
    endfunction

    // Monitor for the N=4 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q4.size() > 0) begin
                chk("tx4", tx4, q4.pop_front());
                chk("busy4", busy4, 1);
                chk("ready4", rdy4, q4.size() == 0);
            end else begin
                chk("idle_tx4", tx4, 1);
                chk("idle_busy4", busy4, 0);
                chk("idle_ready4", rdy4, 1);
            end
        end
    end

    // Monitor for the N=1 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q1.size() > 0) begin
                chk("tx1", tx1, q1.pop_front());
                chk("busy1", busy1, 1);
                chk("ready1", rdy1, q1.size() == 0);
            end else begin
                chk("idle_tx1", tx1, 1);
                chk("idle_busy1", busy1, 0);
                chk("idle_ready1", rdy1, 1);
            end
        end
    end

    task automatic send(input int sel, input logic [15:0] w, input bit hold, output time t);
        bit ok;
        if (sel == 0) begin in4 = w; v4 = 1'b1; end
        else          begin in1 = w; v1 = 1'b1; end
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = (sel == 0) ? rdy4 : rdy1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout sel=%0d word=%h: in_ready never 1, expected 1", sel, w);
            t = 0;
        end else begin
            @(posedge clk);
            t = $time;
            push_frame(sel, w);
        end
        #1;
        if (!hold) begin
            if (sel == 0) v4 = 1'b0;
            else          v1 = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400 && (q4.size() > 0 || q1.size() > 0); k++) @(negedge clk);
        chk("drain_pending", q4.size() + q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    time t1, t2;

    initial begin
        reset = 1'b0; mon_en = 1'b0;
        in4 = 16'h0; in1 = 16'h0; v4 = 1'b0; v1 = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("rst_tx4", tx4, 1);     chk("rst_busy4", busy4, 0); chk("rst_ready4", rdy4, 1);
        chk("rst_tx1", tx1, 1);     chk("rst_busy1", busy1, 0); chk("rst_ready1", rdy1, 1);
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        send(0, 16'hA5C3, 0, t1);
        drain();

        send(0, 16'h0001, 1, t1);
        send(0, 16'hFFFF, 0, t2);
        chk("b2b_spacing4", t2 - t1, 72 * 10);
        drain();

        send(0, 16'h3C5A, 0, t1);
        repeat (10) @(posedge clk);
        #1 in4 = 16'hDEAD; v4 = 1'b1;
        repeat (3) @(posedge clk);
        #1 v4 = 1'b0;
        drain();
        send(0, 16'h0F0F, 0, t1);
        drain();

        send(0, 16'h8000, 0, t1);
        repeat (35) @(posedge clk);
        #2 reset = 1'b1;
        q4.delete();
        #1;
        chk("midrst_tx4", tx4, 1); chk("midrst_busy4", busy4, 0); chk("midrst_ready4", rdy4, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        send(0, 16'h1234, 0, t1);
        drain();

        send(1, 16'h00FF, 1, t1);
        send(1, 16'h8001, 0, t2);
        chk("b2b_spacing1", t2 - t1, 18 * 10);
        drain();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
